// File: rtl/imem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream, instruction-memory write and status bundle for the
//            imem_loader program loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_word;
  logic [LEN_W-1:0]  len;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_word, len, in_byte, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, base_word, len, in_byte, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Assembles a big-endian byte stream into 32-bit words, writes them
//            into instruction memory and holds the CPU until the image is in.
//            Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  if_ldr
);

  localparam int c_AW = $clog2(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_FIN   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd4
  } state_t;
`endif

  state_t            r_state;
  logic [c_AW-1:0]   r_base;
  logic [6:0]        r_len;
  logic [6:0]        r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic              r_in_ready;
  logic              r_we;
  logic [c_AW-1:0]   r_waddr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic              w_len_bad;
  logic              w_last;
  logic [c_AW-1:0]   w_waddr;

  assign w_accept  = if_ldr.in_valid && r_in_ready;
  assign w_len_bad = (if_ldr.len == 7'd0) || (32'(if_ldr.len) > 32'(MAX_LEN));
  assign w_last    = ((r_word_cnt + 7'd1) == r_len);
  // Truncation to the address width gives the modulo-DEPTH wrap for free.
  assign w_waddr   = r_base + r_word_cnt[c_AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_ldr.start) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err      <= 1'b0;
              r_base     <= if_ldr.base_word;
              r_len      <= if_ldr.len;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_csum     <= '0;
`endif
              r_state    <= S_RECV;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], if_ldr.in_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ if_ldr.in_byte;
`endif
            // Fourth byte completes the word; it lands in bits [7:0].
            if (r_byte_cnt == 2'd3) begin
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b1;
              r_waddr    <= w_waddr;
              r_wdata    <= {r_shift, if_ldr.in_byte};
            end
          end
        end

        S_WRITE: begin
          r_word_cnt <= r_word_cnt + 7'd1;
          if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= S_CHECK;
            r_in_ready <= 1'b1;
`else
            r_state    <= S_FIN;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= S_RECV;
            r_in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (if_ldr.in_byte != r_csum) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
`endif

        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ldr.in_ready   = r_in_ready;
  assign if_ldr.imem_we    = r_we;
  assign if_ldr.imem_waddr = r_waddr;
  assign if_ldr.imem_wdata = r_wdata;
  assign if_ldr.busy       = r_busy;
  assign if_ldr.cpu_hold   = r_busy;
  assign if_ldr.done       = r_done;
  assign if_ldr.err        = r_err;

endmodule
`default_nettype wire
